uart_tx_feeder: RTL and testbench

//   Byte FIFO and frame pacer that sits directly upstream of the UART transmitter (inputs writeUart/charOut).
//   The CPU pushes bytes at any rate. This block drains them one per UART frame.
//   For each byte it issues a single-cycle writeUart pulse and holds charOut stable until the next issue.
//   The transmitter has no busy/ready output, so pacing is done purely by cycle count.

---
 rtl/uart_tx_feeder_pkg.sv | 16 +
 rtl/uart_tx_feeder_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_feeder.sv | 77 +++++++
 tb/tb_uart_tx_feeder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants for the UART transmit feeder: default bit timing, guard time and pacer state encodings.
package uart_tx_feeder_pkg;

  localparam int DELAY_FRAMES_DEF = 234;
  localparam int GUARD_DEF        = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // One frame slot is a start bit, 8 data bits and a stop bit, plus the guard clocks.
  function automatic int frameGap(input int delayFrames, input int guard);
    return 10 * delayFrames + guard;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Byte FIFO with registered full/empty flags and a read register that loads only on pop.
module uart_tx_feeder_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      countNext;
  logic             doPush;
  logic             doPop;

  // full is the registered flag, so a push is refused while full even when a pop happens this same cycle.
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_comb begin
    countNext = count;
    if (doPush && !doPop)      countNext = count + 1'b1;
    else if (doPop && !doPush) countNext = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rdData <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) begin
        rdData <= mem[rdPtr];
        rdPtr  <= rdPtr + 1'b1;
      end
      count <= countNext;
      full  <= (countNext == (AW+1)'(DEPTH));
      empty <= (countNext == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Paces bytes from a FIFO into a UART transmitter that has no ready signal: one start pulse per frame slot.
//   state    | meaning
//   ST_IDLE  | waiting for a byte; pops and pulses writeUart as soon as one is queued
//   ST_ISSUE | pulse cycle; writeUart drops on the next edge
//   ST_HOLD  | counting down the rest of the frame slot, charOut held
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEF,
  parameter int DEPTH        = 16,
  parameter int GUARD        = GUARD_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   writeUart,
  output logic [7:0]             charOut
);

  localparam int FRAME_GAP = frameGap(DELAY_FRAMES, GUARD);
  localparam int GW        = $clog2(FRAME_GAP);

  logic [1:0]    state;
  logic [GW-1:0] gap;
  logic          popReq;

  assign popReq = (state == ST_IDLE) && !empty;

  uart_tx_feeder_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (wr_en),
    .pop    (popReq),
    .wrData (wr_data),
    .rdData (charOut),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HOLD;
      gap       <= GW'(FRAME_GAP - 1);
      writeUart <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      writeUart <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            writeUart <= 1'b1;
            gap       <= GW'(FRAME_GAP - 2);
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_HOLD;
        ST_HOLD: begin
          // Leave on the edge where the count reaches zero so pulses land exactly FRAME_GAP apart.
          gap <= gap - 1'b1;
          if (gap < GW'(2)) state <= ST_IDLE;
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-and-schedule reference model checked every cycle, plus directed literal checks.
module tb_uart_tx_feeder;

  localparam int DF  = 4;
  localparam int GD  = 2;
  localparam int DP  = 4;
  localparam int GAP = 10 * DF + GD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, writeUart;
  logic [2:0] count;
  logic [7:0] charOut;

  int vectors = 0;
  int errors  = 0;

  // Reference model: byte queue plus the earliest edge at which the next issue is allowed.
  logic [7:0] q[$];
  logic       mOvf = 1'b0;
  logic       mPulse = 1'b0;
  logic [7:0] mChar = 8'h00;
  int         cyc = 0;
  int         nextOk = GAP;
  int         pre;

  int         pulseCyc[$];
  logic [7:0] pulseChr[$];

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DELAY_FRAMES (DF),
    .DEPTH        (DP),
    .GUARD        (GD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .writeUart (writeUart),
    .charOut   (charOut)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      mOvf   = 1'b0;
      mPulse = 1'b0;
      mChar  = 8'h00;
      cyc    = 0;
      nextOk = GAP;
    end else begin
      cyc++;
      pre    = q.size();
      mPulse = 1'b0;
      if (cyc >= nextOk && pre != 0) begin
        mChar  = q.pop_front();
        mPulse = 1'b1;
        nextOk = cyc + GAP;
      end
      if (wr_en) begin
        if (pre == DP) mOvf = 1'b1;
        else           q.push_back(wr_data);
      end
    end
    #1;
    check("writeUart", writeUart, mPulse);
    check("charOut", charOut, mChar);
    check("count", count, q.size());
    check("full", full, q.size() == DP);
    check("empty", empty, q.size() == 0);
    check("overflow", overflow, mOvf);
    if (rst_n && writeUart) begin
      pulseCyc.push_back(cyc);
      pulseChr.push_back(charOut);
    end
  end

  task automatic waitCyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pushByte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic clearPulses();
    pulseCyc.delete();
    pulseChr.delete();
  endtask

  function automatic int pc(input int i);
    return (i < pulseCyc.size()) ? pulseCyc[i] : -1;
  endfunction

  function automatic logic [7:0] pch(input int i);
    return (i < pulseChr.size()) ? pulseChr[i] : 8'hxx;
  endfunction

  logic [7:0] t3Data [6];
  int         prob;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_charOut", charOut, 8'h00);
    rst_n = 1'b1;

    // Single byte after reset: first pulse must wait out the full reset gap.
    waitCyc(4);
    pushByte(8'h48);
    waitCyc(50);
    check("t1_npulse", pulseCyc.size(), 1);
    check("t1_cyc", pc(0), 42);
    check("t1_chr", pch(0), 8'h48);

    // Back-to-back bytes: pulses exactly one frame slot apart.
    clearPulses();
    pushByte(8'h48);
    pushByte(8'h65);
    pushByte(8'h6C);
    waitCyc(175);
    check("t2_npulse", pulseCyc.size(), 3);
    check("t2_first", pc(0), 84);
    check("t2_gap01", pc(1) - pc(0), 42);
    check("t2_gap12", pc(2) - pc(1), 42);
    check("t2_chr0", pch(0), 8'h48);
    check("t2_chr1", pch(1), 8'h65);
    check("t2_chr2", pch(2), 8'h6C);

    // Six pushes during HOLD into a 4-deep FIFO.
    clearPulses();
    for (int i = 0; i < 6; i++) begin
      t3Data[i] = 8'hA0 + 8'(i);
      pushByte(t3Data[i]);
      if (i == 3) check("t3_full_after4", full, 1);
    end
    check("t3_overflow", overflow, 1);
    check("t3_count", count, 4);
    waitCyc(340);
    check("t3_npulse", pulseCyc.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_order", pch(i), t3Data[i]);

    // Reset mid-HOLD with bytes queued.
    pushByte(8'h11);
    pushByte(8'h22);
    waitCyc(350);
    check("t5_count_before", count, 2);
    rst_n = 1'b0;
    #1;
    check("t5_async_writeUart", writeUart, 0);
    check("t5_async_charOut", charOut, 8'h00);
    check("t5_async_count", count, 0);
    check("t5_async_empty", empty, 1);
    check("t5_async_full", full, 0);
    check("t5_async_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    clearPulses();
    rst_n = 1'b1;
    check("t5_empty_after", empty, 1);
    pushByte(8'h5A);
    waitCyc(50);
    check("t5_npulse", pulseCyc.size(), 1);
    check("t5_cyc", pc(0), 42);
    check("t5_chr", pch(0), 8'h5A);

    // Full FIFO at the pop edge: push refused, pop still happens.
    for (int i = 0; i < 4; i++) pushByte(8'hB0 + 8'(i));
    waitCyc(83);
    check("t4_count_full", count, 4);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en   = 1'b0;
    check("t4_count", count, 3);
    check("t4_overflow", overflow, 1);
    check("t4_pulse", writeUart, 1);
    check("t4_chr", charOut, 8'hB0);

    // Randomized traffic with varying push density and occasional resets.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      case (blk)
        0: prob = 3;
        1: prob = 60;
        2: prob = 1;
        3: prob = 15;
        4: prob = 90;
        default: prob = 5;
      endcase
      for (int c = 0; c < 500; c++) begin
        wr_en   = ($urandom_range(0, 99) < prob);
        wr_data = 8'($urandom);
        rst_n   = ($urandom_range(0, 999) != 0);
        @(negedge clk);
      end
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
    repeat (250) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
